tjunction_phase_scheduler: RTL and testbench



---
 rtl/tl_pkg.sv | 28 ++
 rtl/tl_tick_gen.sv | 26 ++
 rtl/tjunction_phase_scheduler.sv | 132 +++++++++++++
 tb/tb_tjunction_phase_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types for the T-junction phase scheduler: state/phase codes, lamp words, tick counter width.
// TL_ALL_RED_EN adds the ALLRED clearance state (phase code 6).
package tl_pkg;

    localparam int TCNT_W = 8;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        TURN_G = 3'd2,
        TURN_Y = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5
`ifdef TL_ALL_RED_EN
        , ALLRED = 3'd6
`endif
    } tl_state_e;

    // A phase of N ticks ends on the tick where the counter holds N-1.
    function automatic logic [TCNT_W-1:0] last_tick(input int ticks);
        return TCNT_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags a tick on the terminal count; clr restarts it.
module tl_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tjunction_phase_scheduler.sv
// Demand-driven phase scheduler for signal heads M1/MT/M2/S with latched turn/side requests.
// Define TL_ALL_RED_EN to insert an all-red clearance phase after every yellow.
module tjunction_phase_scheduler
    import tl_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int T_MIN_MAIN = 10,
    parameter int T_YEL      = 3,
    parameter int T_TURN     = 5,
    parameter int T_SIDE     = 8,
    parameter int T_ALLRED   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_turn,
    input  logic       req_side,
    output logic [2:0] led_M1,
    output logic [2:0] led_MT,
    output logic [2:0] led_M2,
    output logic [2:0] led_S,
    output logic [2:0] phase
);

    localparam logic [TCNT_W-1:0] LAST_MAIN   = last_tick(T_MIN_MAIN);
    localparam logic [TCNT_W-1:0] LAST_YEL    = last_tick(T_YEL);
    localparam logic [TCNT_W-1:0] LAST_TURN   = last_tick(T_TURN);
    localparam logic [TCNT_W-1:0] LAST_SIDE   = last_tick(T_SIDE);
    localparam logic [TCNT_W-1:0] LAST_ALLRED = last_tick(T_ALLRED);

    tl_state_e         state_q, state_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [TCNT_W-1:0] last_cnt;
    logic              turn_pend_q, side_pend_q;
    logic              tick, done, state_chg;
`ifdef TL_ALL_RED_EN
    tl_state_e         yel_q;
`endif

    // Decision taken when leaving a yellow (or the clearance that followed it).
    function automatic tl_state_e after_yellow(input tl_state_e from, input logic tp, input logic sp);
        case (from)
            MAIN_Y:  return tp ? TURN_G : SIDE_G;
            TURN_Y:  return sp ? SIDE_G : MAIN_G;
            default: return MAIN_G;
        endcase
    endfunction

    tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .tick (tick)
    );

    always_comb begin
        case (state_q)
            MAIN_G:                 last_cnt = LAST_MAIN;
            MAIN_Y, TURN_Y, SIDE_Y: last_cnt = LAST_YEL;
            TURN_G:                 last_cnt = LAST_TURN;
            SIDE_G:                 last_cnt = LAST_SIDE;
            default:                last_cnt = LAST_ALLRED;
        endcase
    end

    assign done = tick && (tcnt_q >= last_cnt);

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_G: if (done && (turn_pend_q || side_pend_q)) state_d = MAIN_Y;
            MAIN_Y, TURN_Y, SIDE_Y: begin
                if (done) begin
`ifdef TL_ALL_RED_EN
                    state_d = ALLRED;
`else
                    state_d = after_yellow(state_q, turn_pend_q, side_pend_q);
`endif
                end
            end
            TURN_G: if (done) state_d = TURN_Y;
            SIDE_G: if (done) state_d = SIDE_Y;
`ifdef TL_ALL_RED_EN
            ALLRED: if (done) state_d = after_yellow(yel_q, turn_pend_q, side_pend_q);
`endif
            default: state_d = MAIN_G;
        endcase
    end

    assign state_chg = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= MAIN_G;
            tcnt_q      <= '0;
            turn_pend_q <= 1'b0;
            side_pend_q <= 1'b0;
`ifdef TL_ALL_RED_EN
            yel_q       <= MAIN_Y;
`endif
        end else begin
            state_q <= state_d;
            if (state_chg) begin
                tcnt_q <= '0;
            end else if (tick && (tcnt_q != '1)) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
            // Entry into the served phase clears the latch even if the detector is still high.
            turn_pend_q <= (state_chg && state_d == TURN_G) ? 1'b0 : (turn_pend_q | req_turn);
            side_pend_q <= (state_chg && state_d == SIDE_G) ? 1'b0 : (side_pend_q | req_side);
`ifdef TL_ALL_RED_EN
            if (state_chg && state_d == ALLRED) begin
                yel_q <= state_q;
            end
`endif
        end
    end

    always_comb begin
        case (state_q)
            MAIN_G:  {led_M1, led_MT, led_M2, led_S} = {GRN, RED, GRN, RED};
            MAIN_Y:  {led_M1, led_MT, led_M2, led_S} = {YEL, RED, YEL, RED};
            TURN_G:  {led_M1, led_MT, led_M2, led_S} = {RED, GRN, RED, RED};
            TURN_Y:  {led_M1, led_MT, led_M2, led_S} = {RED, YEL, RED, RED};
            SIDE_G:  {led_M1, led_MT, led_M2, led_S} = {RED, RED, RED, GRN};
            SIDE_Y:  {led_M1, led_MT, led_M2, led_S} = {RED, RED, RED, YEL};
            default: {led_M1, led_MT, led_M2, led_S} = {RED, RED, RED, RED};
        endcase
    end

    assign phase = state_q;

endmodule

// File: tb/tb_tjunction_phase_scheduler.sv
// Directed table-driven bench for tjunction_phase_scheduler (TICK_DIV=4, short phase durations).
module tb_tjunction_phase_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_turn = 1'b0;
    logic       req_side = 1'b0;
    logic [2:0] led_M1, led_MT, led_M2, led_S, phase;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit do_rst;
        bit rt;
        bit rs;
        int n;
        int ph;
    } vec_t;

    vec_t vecs[$];

    tjunction_phase_scheduler #(
        .TICK_DIV   (4),
        .T_MIN_MAIN (3),
        .T_YEL      (2),
        .T_TURN     (2),
        .T_SIDE     (3),
        .T_ALLRED   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_turn (req_turn),
        .req_side (req_side),
        .led_M1   (led_M1),
        .led_MT   (led_MT),
        .led_M2   (led_M2),
        .led_S    (led_S),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_leds(input int ph);
        case (ph)
            0:       return {G, R, G, R};
            1:       return {Y, R, Y, R};
            2:       return {R, G, R, R};
            3:       return {R, Y, R, R};
            4:       return {R, R, R, G};
            5:       return {R, R, R, Y};
            default: return {R, R, R, R};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int ph, output bit bad);
        logic [11:0] act;
        act = {led_M1, led_MT, led_M2, led_S};
        checks++;
        bad = 1'b0;
        if (phase !== 3'(ph) || act !== exp_leds(ph)) begin
            failures++;
            bad = 1'b1;
            $display("FAIL %s: got phase=%0d leds=%b, expected phase=%0d leds=%b",
                     name, phase, act, ph, exp_leds(ph));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    task automatic add(input bit r, input bit t, input bit s, input int n, input int ph);
        vec_t v;
        v.do_rst = r; v.rt = t; v.rs = s; v.n = n; v.ph = ph;
        vecs.push_back(v);
    endtask

    // All-red clearance record; contributes nothing in the default build.
    task automatic add_ar();
`ifdef TL_ALL_RED_EN
        add(0, 0, 0, 8, 6);
`endif
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int errs;
        bit bad;
        errs = 0;
        if (v.do_rst) do_reset();
        req_turn = v.rt;
        req_side = v.rs;
        for (int k = 0; k < v.n; k++) begin
            check($sformatf("vec%0d cyc%0d", idx, k), v.ph, bad);
            if (bad) errs++;
            step();
            req_turn = 1'b0;
            req_side = 1'b0;
        end
        $display("vec %0d: rst=%0d req_turn=%0d req_side=%0d phase %0d for %0d cycles, errors=%0d",
                 idx, v.do_rst, v.rt, v.rs, v.ph, v.n, errs);
    endtask

    initial begin
        vec_t v;
        bit bad;

        // Idle after reset: main green holds with no demand.
        add(1, 0, 0, 200, 0);
        // Side request only.
        add(1, 0, 1, 12, 0); add(0, 0, 0, 8, 1); add_ar(); add(0, 0, 0, 12, 4); add(0, 0, 0, 8, 5); add_ar(); add(0, 0, 0, 4, 0);
        // Turn and side together: turn first, side after TURN_Y.
        add(1, 1, 1, 12, 0); add(0, 0, 0, 8, 1); add_ar(); add(0, 0, 0, 8, 2); add(0, 0, 0, 8, 3); add_ar();
        add(0, 0, 0, 12, 4); add(0, 0, 0, 8, 5); add_ar(); add(0, 0, 0, 4, 0);
        // Turn only: side phases skipped, then main green holds.
        add(1, 1, 0, 12, 0); add(0, 0, 0, 8, 1); add_ar(); add(0, 0, 0, 8, 2); add(0, 0, 0, 8, 3); add_ar(); add(0, 0, 0, 40, 0);
        // Turn, then side request arriving during TURN_Y.
        add(1, 1, 0, 12, 0); add(0, 0, 0, 8, 1); add_ar(); add(0, 0, 0, 8, 2); add(0, 0, 1, 8, 3); add_ar();
        add(0, 0, 0, 12, 4); add(0, 0, 0, 8, 5); add_ar(); add(0, 0, 0, 4, 0);
        // Side pending, turn arriving during MAIN_Y is honoured with priority.
        add(1, 0, 1, 12, 0); add(0, 1, 0, 8, 1); add_ar(); add(0, 0, 0, 8, 2); add(0, 0, 0, 8, 3); add_ar();
        add(0, 0, 0, 12, 4); add(0, 0, 0, 8, 5); add_ar(); add(0, 0, 0, 4, 0);
        // Turn request on the cycle TURN_G is entered is absorbed by the clear.
        add(1, 1, 0, 12, 0);
`ifdef TL_ALL_RED_EN
        add(0, 0, 0, 8, 1); add(0, 0, 0, 7, 6); add(0, 1, 0, 1, 6);
`else
        add(0, 0, 0, 7, 1); add(0, 1, 0, 1, 1);
`endif
        add(0, 0, 0, 8, 2); add(0, 0, 0, 8, 3); add_ar(); add(0, 0, 0, 30, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of SIDE_G with a turn request pending.
        v = '{1, 0, 1, 12, 0}; run_vec(1000, v);
        v = '{0, 0, 0, 8, 1};  run_vec(1001, v);
`ifdef TL_ALL_RED_EN
        v = '{0, 0, 0, 8, 6};  run_vec(1002, v);
`endif
        v = '{0, 1, 0, 6, 4};  run_vec(1003, v);
        rst = 1'b0;
        step();
        check("midphase_reset", 0, bad);
        $display("midphase reset: phase=%0d leds=%b%b%b%b", phase, led_M1, led_MT, led_M2, led_S);
        rst = 1'b1;
        v = '{0, 0, 0, 40, 0}; run_vec(1004, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
